// File: rtl/m_clint.sv
// Core-local interruptor: 64-bit mtime, per-hart mtimecmp and msip, and the timer interrupts.
// Optional mtime prescaler is compiled in with CLINT_PRESCALER_EN.
module m_clint #(
    parameter int N_HARTS  = 1,
    parameter int PRESCALE = 1
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic               w_re,
    input  logic               w_we,
    input  logic [15:0]        w_addr,
    input  logic [31:0]        w_wdata,
    output logic [31:0]        w_rdata,
    output logic               w_rvalid,
    output logic [63:0]        w_mtime,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip
);

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp [N_HARTS];
    logic [N_HARTS-1:0] msip;

    // Address decode; bits [1:0] are don't-care.
    logic        in_msip;
    logic        in_cmp;
    logic        cmp_hi;
    logic [11:0] msip_idx;
    logic [10:0] cmp_idx;
    logic        mtime_lo_sel;
    logic        mtime_hi_sel;

    assign in_msip      = (w_addr[15:14] == 2'b00);
    assign in_cmp       = (w_addr[15:14] == 2'b01);
    assign msip_idx     = w_addr[13:2];
    assign cmp_idx      = w_addr[13:3];
    assign cmp_hi       = w_addr[2];
    assign mtime_lo_sel = (w_addr[15:2] == 14'h2FFE);
    assign mtime_hi_sel = (w_addr[15:2] == 14'h2FFF);

    logic [N_HARTS-1:0] msip_we;
    logic [N_HARTS-1:0] cmp_lo_we;
    logic [N_HARTS-1:0] cmp_hi_we;
    logic [31:0]        rd_val;

    always_comb begin
        msip_we   = '0;
        cmp_lo_we = '0;
        cmp_hi_we = '0;
        rd_val    = '0;
        if (mtime_lo_sel) rd_val = mtime[31:0];
        if (mtime_hi_sel) rd_val = mtime[63:32];
        for (int h = 0; h < N_HARTS; h++) begin
            if (in_msip && msip_idx == 12'(h)) begin
                rd_val     = {31'b0, msip[h]};
                msip_we[h] = w_we;
            end
            if (in_cmp && cmp_idx == 11'(h)) begin
                rd_val       = cmp_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
                cmp_lo_we[h] = w_we && !cmp_hi;
                cmp_hi_we[h] = w_we && cmp_hi;
            end
        end
    end

    logic tick;

`ifdef CLINT_PRESCALER_EN
    logic [15:0] pre_cnt;
    logic        unused_addr;

    assign tick        = (pre_cnt == 16'(PRESCALE - 1));
    assign unused_addr = ^w_addr[1:0];

    // Free-running divider; mtime writes deliberately leave its phase alone.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) pre_cnt <= '0;
        else        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
    end
`else
    logic unused_cfg;

    assign tick       = 1'b1;
    assign unused_cfg = ^{w_addr[1:0], 16'(PRESCALE)};
`endif

    // A write to either half wins over the tick; the other half keeps its pre-increment value.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mtime <= '0;
        end else if (w_we && mtime_lo_sel) begin
            mtime <= {mtime[63:32], w_wdata};
        end else if (w_we && mtime_hi_sel) begin
            mtime <= {w_wdata, mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int h = 0; h < N_HARTS; h++) mtimecmp[h] <= '1;
            msip <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (cmp_lo_we[h]) mtimecmp[h][31:0]  <= w_wdata;
                if (cmp_hi_we[h]) mtimecmp[h][63:32] <= w_wdata;
                if (msip_we[h])   msip[h]            <= w_wdata[0];
            end
        end
    end

    // Compare uses the registered values, so any write shows up on w_mtip one cycle later.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            w_mtip <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) w_mtip[h] <= (mtime >= mtimecmp[h]);
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            w_rvalid <= 1'b0;
            w_rdata  <= '0;
        end else begin
            w_rvalid <= w_re;
            w_rdata  <= w_re ? rd_val : 32'd0;
        end
    end

    assign w_mtime = mtime;
    assign w_msip  = msip;

endmodule

// File: tb/tb_m_clint.sv
// Bench for m_clint: directed tables and sequences plus random traffic against a register-map model.
module tb_m_clint;

    localparam int N_HARTS  = 2;
    localparam int PRESCALE = 4;
`ifdef CLINT_PRESCALER_EN
    localparam int DIV = PRESCALE;
`else
    localparam int DIV = 1;
`endif

    logic               CLK;
    logic               RST_X;
    logic               w_re;
    logic               w_we;
    logic [15:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rdata;
    logic               w_rvalid;
    logic [63:0]        w_mtime;
    logic [N_HARTS-1:0] w_mtip;
    logic [N_HARTS-1:0] w_msip;

    m_clint #(.N_HARTS(N_HARTS), .PRESCALE(PRESCALE)) dut (
        .CLK(CLK), .RST_X(RST_X), .w_re(w_re), .w_we(w_we), .w_addr(w_addr),
        .w_wdata(w_wdata), .w_rdata(w_rdata), .w_rvalid(w_rvalid),
        .w_mtime(w_mtime), .w_mtip(w_mtip), .w_msip(w_msip)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [63:0]        m_mtime;
    logic [63:0]        m_cmp [N_HARTS];
    logic [N_HARTS-1:0] m_msip;
    logic [N_HARTS-1:0] m_mtip;
    int                 m_pc;
    logic [31:0]        exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime = 64'd0;
        for (int h = 0; h < N_HARTS; h++) m_cmp[h] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip = '0;
        m_mtip = '0;
        m_pc   = 0;
        exp_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] addr);
        int a;
        int o;
        a = int'(addr) & 'hFFFC;
        if (a < 4 * N_HARTS) return {31'b0, m_msip[a / 4]};
        if (a >= 'h4000 && a < 'h4000 + 8 * N_HARTS) begin
            o = a - 'h4000;
            return (o % 8 == 4) ? m_cmp[o / 8][63:32] : m_cmp[o / 8][31:0];
        end
        if (a == 'hBFF8) return m_mtime[31:0];
        if (a == 'hBFFC) return m_mtime[63:32];
        return 32'd0;
    endfunction

    // One clock of the model: reads see pre-write state, mtip sees pre-edge state.
    task automatic model_step(input logic re, input logic we, input logic [15:0] addr,
                              input logic [31:0] wdata);
        logic [N_HARTS-1:0] nxt_mtip;
        logic               tick;
        int                 a;
        int                 o;
        if (re) exp_q.push_back(model_read(addr));
        for (int h = 0; h < N_HARTS; h++) nxt_mtip[h] = (m_mtime >= m_cmp[h]);
        if (DIV == 1) begin
            tick = 1'b1;
        end else begin
            tick = (m_pc == DIV - 1);
            m_pc = tick ? 0 : m_pc + 1;
        end
        a = int'(addr) & 'hFFFC;
        if (we && a == 'hBFF8)      m_mtime = {m_mtime[63:32], wdata};
        else if (we && a == 'hBFFC) m_mtime = {wdata, m_mtime[31:0]};
        else if (tick)              m_mtime = m_mtime + 64'd1;
        if (we && a < 4 * N_HARTS) m_msip[a / 4] = wdata[0];
        if (we && a >= 'h4000 && a < 'h4000 + 8 * N_HARTS) begin
            o = a - 'h4000;
            if (o % 8 == 4) m_cmp[o / 8][63:32] = wdata;
            else            m_cmp[o / 8][31:0]  = wdata;
        end
        m_mtip = nxt_mtip;
    endtask

    // Driver: apply one cycle of inputs, advance model, compare after the edge.
    task automatic cycle(input logic re, input logic we, input logic [15:0] addr,
                         input logic [31:0] wdata);
        logic [31:0] exp_rd;
        w_re    = re;
        w_we    = we;
        w_addr  = addr;
        w_wdata = wdata;
        model_step(re, we, addr, wdata);
        @(posedge CLK);
        #1;
        w_re = 1'b0;
        w_we = 1'b0;
        check("mtime", w_mtime, m_mtime);
        check("mtip", 64'(w_mtip), 64'(m_mtip));
        check("msip", 64'(w_msip), 64'(m_msip));
        check("rvalid", 64'(w_rvalid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            exp_rd = exp_q.pop_front();
            check("rdata", 64'(w_rdata), 64'(exp_rd));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mtime"}, w_mtime, 64'd0);
        check({tag, "_mtip"}, 64'(w_mtip), 64'd0);
        check({tag, "_msip"}, 64'(w_msip), 64'd0);
        check({tag, "_rvalid"}, 64'(w_rvalid), 64'd0);
        check({tag, "_rdata"}, 64'(w_rdata), 64'd0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    logic [15:0] addr_pool [12];

    initial begin
        bit found;
        logic [15:0] ra;
        logic [31:0] rd;
        logic        rre;
        logic        rwe;
        int          k;

        vecs[0] = '{16'h0004, 32'h0000_0003, 32'h0000_0001};
        vecs[1] = '{16'h0008, 32'h0000_0001, 32'h0000_0000};
        vecs[2] = '{16'h0000, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[3] = '{16'h4008, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{16'h400F, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vecs[5] = '{16'h4010, 32'h0000_0005, 32'h0000_0000};
        vecs[6] = '{16'h1234, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7] = '{16'h8000, 32'h0000_0001, 32'h0000_0000};

        addr_pool = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                      16'h400C, 16'h4010, 16'hBFF8, 16'hBFFC, 16'hBFF4, 16'h4002};

        RST_X   = 1'b0;
        w_re    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST_X = 1'b1;

        // Ten cycles after reset release
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0, 32'h0);
        check("ten_cycles_mtime", w_mtime, 64'(10 / DIV));
        check("ten_cycles_mtip", 64'(w_mtip), 64'd0);
        cycle(1'b1, 1'b0, 16'h4000, 32'h0);
        check("cmp_reset_read", 64'(w_rdata), 64'hFFFF_FFFF);

        // mtimecmp = 20 programmed at mtime 5
        cycle(1'b0, 1'b1, 16'hBFF8, 32'd5);
        check("mtime_load5", w_mtime, 64'd5);
        cycle(1'b0, 1'b1, 16'h4000, 32'd20);
        cycle(1'b0, 1'b1, 16'h4004, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle(1'b0, 1'b0, 16'h0, 32'h0);
            if (w_mtime == 64'd20) found = 1'b1;
        end
        check("reach_20", 64'(found), 64'd1);
        check("mtip_at_20", 64'(w_mtip[0]), 64'd0);
        cycle(1'b0, 1'b0, 16'h0, 32'h0);
        check("mtip_after_20", 64'(w_mtip[0]), 64'd1);

        // Simultaneous read and write returns the old value
        cycle(1'b1, 1'b1, 16'h4000, 32'd1000);
        check("rw_same_old", 64'(w_rdata), 64'd20);
        cycle(1'b1, 1'b0, 16'h4000, 32'd0);
        check("rw_same_new", 64'(w_rdata), 64'd1000);

        // 64-bit wraparound
        cycle(1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFE);
        cycle(1'b0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF);
        check("mtime_preload", w_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
        for (int i = 0; i < 2 * DIV; i++) cycle(1'b0, 1'b0, 16'h0, 32'h0);
        check("mtime_wrap", w_mtime, 64'd0);

        // Register map table
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, vecs[i].addr, vecs[i].wdata);
            cycle(1'b1, 1'b0, vecs[i].addr, 32'h0);
            check($sformatf("table%0d_rdata", i), 64'(w_rdata), 64'(vecs[i].exp));
        end
        check("table_msip", 64'(w_msip), 64'h2);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            k   = $urandom_range(0, 12);
            ra  = (k == 12) ? 16'($urandom) : addr_pool[k];
            rd  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
            rre = 1'($urandom_range(0, 1));
            rwe = ($urandom_range(0, 3) == 0);
            cycle(rre, rwe, ra, rd);
        end

        // Reset during an in-flight read with mtime = 100
        cycle(1'b0, 1'b1, 16'hBFFC, 32'd0);
        cycle(1'b0, 1'b1, 16'hBFF8, 32'd100);
        check("mtime_100", w_mtime, 64'd100);
        w_re   = 1'b1;
        w_addr = 16'hBFF8;
        #2;
        RST_X = 1'b0;
        #1;
        check_reset_outputs("midread");
        w_re = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("held");
        RST_X = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 32'h0);
        check("post_reset_mtime", w_mtime, 64'(3 / DIV));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_clint.md
M_CLINT -- requirements
Module: m_clint

Interface
REQ-001 SHALL have parameter N_HARTS, default 1, number of harts served (1..16).
REQ-002 SHALL have parameter PRESCALE, default 1, CLK cycles per mtime tick; used only when CLINT_PRESCALER_EN is defined; legal range 1..65535.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_X  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port w_re  input  1  read strobe, one request per asserted cycle.
REQ-006 SHALL have port w_we  input  1  write strobe, one request per asserted cycle.
REQ-007 SHALL have port w_addr  input  16  byte offset within the CLINT window; bits [1:0] ignored.
REQ-008 SHALL have port w_wdata  input  32  write data.
REQ-009 SHALL have port w_rdata  output  32  read data.
REQ-010 SHALL have port w_rvalid  output  1  one-cycle pulse qualifying w_rdata.
REQ-011 SHALL have port w_mtime  output  64  current mtime, feeding the cluster's w_mtime.
REQ-012 SHALL have port w_mtip  output  N_HARTS  per-hart machine timer interrupt pending.
REQ-013 SHALL have port w_msip  output  N_HARTS  per-hart machine software interrupt pending.

Function
REQ-014 SHALL decode the map: msip[h] at 0x0000+4h; mtimecmp[h] low at 0x4000+8h, high at 0x4004+8h; mtime low at 0xBFF8, high at 0xBFFC.
REQ-015 SHALL treat unmapped offsets and hart indices h>=N_HARTS as read-zero, write-ignored, still pulsing w_rvalid on read.
REQ-016 SHALL store only w_wdata[0] into msip[h]; msip reads return {31'b0, msip[h]}.
REQ-017 SHALL return read data with w_rvalid exactly 1 cycle after the w_re cycle; back-to-back reads every cycle are supported.
REQ-018 SHALL commit writes at the end of the w_we cycle; no acknowledge, no stall.
REQ-019 SHALL, when w_re and w_we target the same register in one cycle, perform the write and return the pre-write value.
REQ-020 SHALL increment mtime by 1 every tick as a full 64-bit add; the low-word carry propagates into the high word; 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-021 SHALL, on a write to an mtime half in a tick cycle, load the written half and leave the other half as it was before the increment; the increment is dropped for that cycle.
REQ-022 SHALL register w_mtip[h] = (mtime >= mtimecmp[h]) as unsigned 64-bit, evaluated on current register values; it asserts 1 cycle after the condition first holds.
REQ-023 SHALL update w_mtip[h] 1 cycle after any mtimecmp or mtime write; clearing requires software to raise mtimecmp.
REQ-024 SHALL drive w_msip directly from the msip registers with no extra latency.

Reset
REQ-025 SHALL asynchronously clear on RST_X low: mtime=0, msip=0, w_mtip=0, w_rvalid=0, w_rdata=0, and prescaler count=0.
REQ-026 SHALL asynchronously set every mtimecmp[h] to 0xFFFFFFFF_FFFFFFFF on RST_X low.
REQ-027 SHALL abort any in-flight read on reset, with no w_rvalid pulse after reset deassertion.

Configuration
REQ-028 SHALL, with CLINT_PRESCALER_EN defined, generate a tick when a counter counting 0..PRESCALE-1 wraps; mtime writes do not reset the counter.
REQ-029 SHALL, without CLINT_PRESCALER_EN, tick every CLK cycle, ignore PRESCALE, and contain no prescaler logic.

Verification
REQ-030 SHALL cover: reset release, then 10 cycles -> w_mtime=10, w_mtip=0, and a read of 0x4000 returns 0xFFFFFFFF.
REQ-031 SHALL cover: write 0x4000=20 and 0x4004=0 at mtime 5 -> w_mtip[0] rises exactly 1 cycle after w_mtime reaches 20.
REQ-032 SHALL cover: write 0xBFF8=0xFFFFFFFE and 0xBFFC=0xFFFFFFFF -> after 2 further ticks w_mtime=0 and mtime wraparound is observed.
REQ-033 SHALL cover: N_HARTS=2, write 0x0004=0x3 -> w_msip=2'b10; a read of 0x0004 returns 0x1; a write to 0x0008 is ignored and a read of it returns 0.
REQ-034 SHALL cover: CLINT_PRESCALER_EN defined, PRESCALE=4, 40 cycles -> w_mtime=10.
REQ-035 SHALL cover: RST_X asserted mid-read with mtime=100 -> no w_rvalid, and all outputs hold reset values immediately.
